// File: rtl/dec138_rr_sched.sv
// ============================================================================
// dec138_rr_sched : round-robin scheduler for eight requesters that drives one
//                   shared 74138-style active-low decoder, with registered outputs.
// Revision 1.0
// ============================================================================
`default_nettype none

module dec138_rr_sched #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       G1,
    input  logic       G2a,
    input  logic       G2b,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] Y,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q;
    logic [2:0]    ptr_q;
    logic [2:0]    sel_q;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [7:0]    y_q;
    logic          gv_q;
    logic          to_q;

    logic          en;
    logic          hold_lim;
    logic          pick_vld;
    logic [2:0]    pick_idx;
    logic [2:0]    cand;

    assign en       = G1 & ~G2a & ~G2b;
    assign hold_lim = (hold_q == HW'(HOLD_MAX - 1));
    assign hold_d   = (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + HW'(1);

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = '0;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + 3'(k);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            hold_q  <= '0;
            y_q     <= 8'hFF;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            to_q <= 1'b0;
            if (!en) begin
                // Aborted grant: no rotation, no timeout.
                state_q <= S_IDLE;
                hold_q  <= '0;
                y_q     <= 8'hFF;
                gv_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pick_vld) begin
                            state_q <= S_GRANT;
                            sel_q   <= pick_idx;
                            hold_q  <= '0;
                            y_q     <= ~(8'b1 << pick_idx);
                            gv_q    <= 1'b1;
                        end else begin
                            y_q  <= 8'hFF;
                            gv_q <= 1'b0;
                        end
                    end
                    S_GRANT: begin
                        if (done || !req[sel_q] || hold_lim) begin
                            state_q <= S_GAP;
                            ptr_q   <= sel_q + 3'd1;
                            y_q     <= 8'hFF;
                            gv_q    <= 1'b0;
                            to_q    <= hold_lim & ~done & req[sel_q];
                        end else begin
                            hold_q <= hold_d;
                        end
                    end
                    S_GAP: begin
                        state_q <= S_IDLE;
                        y_q     <= 8'hFF;
                        gv_q    <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        y_q     <= 8'hFF;
                        gv_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel       = sel_q;
    assign Y         = y_q;
    assign gnt_valid = gv_q;
    assign timeout   = to_q;

endmodule

`default_nettype wire

// File: tb/tb_dec138_rr_sched.sv
// ============================================================================
// tb_dec138_rr_sched : directed scoreboard checks plus a random invariant phase
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dec138_rr_sched;

    localparam int HOLD_MAX = 4;
    localparam int BOUND    = 8 * (HOLD_MAX + 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       G1, G2a, G2b;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] Y;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    dec138_rr_sched #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .G1        (G1),
        .G2a       (G2a),
        .G2b       (G2b),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .Y         (Y),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] ey, input logic [2:0] es,
                       input logic eg, input logic et);
        exp_t e;
        e.tag = tag;
        e.v   = {ey, es, eg, et};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_chk++;
        assert ({Y, sel, gnt_valid, timeout} === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed Y=%h sel=%0d gv=%b to=%b, expected Y=%h sel=%0d gv=%b to=%b",
                   e.tag, Y, sel, gnt_valid, timeout, e.v[12:5], e.v[4:2], e.v[1], e.v[0]);
        end
    endtask

    initial begin
        int         waitc [8];
        logic       en_prev, rst_prev;
        logic [7:0] req_prev;
        logic [7:0] ey;
        int         i;

        rst = 1'b1; G1 = 1'b1; G2a = 1'b0; G2b = 1'b0; req = 8'h00; done = 1'b0;
        chk("reset", 8'hFF, 3'd0, 1'b0, 1'b0);

        // Single requester: grant, release, gap, re-grant
        rst = 1'b0; req = 8'h01;
        chk("grant0", 8'hFE, 3'd0, 1'b1, 1'b0);
        done = 1'b1; chk("rel0", 8'hFF, 3'd0, 1'b0, 1'b0);
        done = 1'b0; chk("gap0", 8'hFF, 3'd0, 1'b0, 1'b0);
        chk("regrant0", 8'hFE, 3'd0, 1'b1, 1'b0);
        done = 1'b1; chk("rel0b", 8'hFF, 3'd0, 1'b0, 1'b0);
        done = 1'b0; req = 8'hFF;
        chk("gap0b", 8'hFF, 3'd0, 1'b0, 1'b0);

        // All requesting: rotation 1..7, wrap to 0, then 1
        for (int k = 0; k < 9; k++) begin
            i  = (1 + k) % 8;
            ey = ~(8'h01 << i);
            chk($sformatf("rr_grant%0d", i), ey, 3'(i), 1'b1, 1'b0);
            done = 1'b1; chk($sformatf("rr_rel%0d", i), 8'hFF, 3'(i), 1'b0, 1'b0);
            done = 1'b0; chk($sformatf("rr_gap%0d", i), 8'hFF, 3'(i), 1'b0, 1'b0);
        end

        // Hold limit: grant 2 for exactly HOLD_MAX cycles, timeout, gap, grant 5
        req = 8'h24;
        for (int k = 0; k < HOLD_MAX; k++)
            chk($sformatf("hold2_c%0d", k), 8'hFB, 3'd2, 1'b1, 1'b0);
        chk("timeout2", 8'hFF, 3'd2, 1'b0, 1'b1);
        chk("gap2", 8'hFF, 3'd2, 1'b0, 1'b0);
        chk("grant5", 8'hDF, 3'd5, 1'b1, 1'b0);

        // Request drop releases; rotation from 6 reaches 3
        req = 8'h08;
        chk("drop5", 8'hFF, 3'd5, 1'b0, 1'b0);
        chk("gap5", 8'hFF, 3'd5, 1'b0, 1'b0);
        chk("grant3", 8'hF7, 3'd3, 1'b1, 1'b0);

        // G2a abort: ptr must not rotate past 3
        G2a = 1'b1; req = 8'h18;
        chk("abort3", 8'hFF, 3'd3, 1'b0, 1'b0);
        chk("disabled", 8'hFF, 3'd3, 1'b0, 1'b0);
        G2a = 1'b0;
        chk("regrant3", 8'hF7, 3'd3, 1'b1, 1'b0);

        // done coincident with hold limit: release without timeout
        for (int k = 1; k < HOLD_MAX; k++)
            chk($sformatf("hold3_c%0d", k), 8'hF7, 3'd3, 1'b1, 1'b0);
        done = 1'b1; chk("done_at_limit", 8'hFF, 3'd3, 1'b0, 1'b0);
        done = 1'b0; chk("gap3", 8'hFF, 3'd3, 1'b0, 1'b0);
        chk("grant4", 8'hEF, 3'd4, 1'b1, 1'b0);
        chk("grant4_hold", 8'hEF, 3'd4, 1'b1, 1'b0);

        // Reset mid-grant clears ptr, so 3 wins over 4 afterwards
        rst = 1'b1; chk("rst_mid", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst = 1'b0; chk("post_rst", 8'hF7, 3'd3, 1'b1, 1'b0);
        G1 = 1'b0; chk("g1_abort", 8'hFF, 3'd3, 1'b0, 1'b0);
        G1 = 1'b1; chk("g1_regrant", 8'hF7, 3'd3, 1'b1, 1'b0);

        // Random phase: invariants and starvation bound
        for (int k = 0; k < 8; k++) waitc[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(99) == 0);
            G1   = ($urandom_range(19) != 0);
            G2a  = ($urandom_range(29) == 0);
            G2b  = ($urandom_range(29) == 0);
            if ($urandom_range(7) == 0) req = 8'($urandom);
            done = ($urandom_range(5) == 0);
            en_prev  = G1 & ~G2a & ~G2b;
            rst_prev = rst;
            req_prev = req;
            @(posedge clk);
            #1;
            n_chk++;
            assert (Y === 8'hFF || $onehot(~Y)) else begin
                n_fail++;
                $error("FAIL rnd_onehot: observed Y=%h, expected FF or one bit low", Y);
            end
            n_chk++;
            assert (gnt_valid === (Y != 8'hFF)) else begin
                n_fail++;
                $error("FAIL rnd_gv: observed gv=%b, expected %b", gnt_valid, Y != 8'hFF);
            end
            n_chk++;
            assert ((en_prev && !rst_prev) || Y === 8'hFF) else begin
                n_fail++;
                $error("FAIL rnd_no_en: observed Y=%h, expected FF", Y);
            end
            for (int k = 0; k < 8; k++) begin
                if (rst_prev || !en_prev || !req_prev[k] || !Y[k]) waitc[k] = 0;
                else waitc[k]++;
                n_chk++;
                assert (waitc[k] <= BOUND) else begin
                    n_fail++;
                    $error("FAIL rnd_starve%0d: observed wait=%0d, expected <= %0d", k, waitc[k], BOUND);
                    waitc[k] = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
